// File: rtl/multi_issue_pre_fetch_pkg.sv
// Shared types and constants for the multi-issue pre-fetch stage.
package multi_issue_pre_fetch_pkg;

  localparam int          MAX_FW         = 4;
  localparam logic [4:0]  EXCCODE_ADEL   = 5'h04;
  localparam logic [4:0]  EXCCODE_TLBL   = 5'h02;
  localparam logic [31:0] PFS_RESET_PC   = 32'hbfc00000;
  localparam logic [31:0] PFS_EX_VEC     = 32'hbfc00380;
  localparam logic [31:0] PFS_REFILL_VEC = 32'hbfc00200;

  // mask is sized for the widest group; narrower builds use the low bits only
  typedef struct packed {
    logic [31:0]       pc;
    logic [MAX_FW-1:0] mask;
    logic              ex;
    logic [4:0]        exccode;
    logic              tlb_refill;
  } fetch_req_t;

endpackage

// File: rtl/multi_issue_pre_fetch_if.sv
// MMU, I-cache request and fetch-queue signals of the pre-fetch stage.
interface multi_issue_pre_fetch_if #(parameter int FETCH_WIDTH = 2) ();
  logic [31:0]            inst_vaddr;
  logic                   inst_tlb_ex;
  logic [4:0]             inst_tlb_exccode;
  logic                   inst_tlb_refill;
  logic                   icache_req;
  logic                   icache_addr_ok;
  logic                   fq_valid;
  logic                   fq_ready;
  logic [31:0]            fq_pc;
  logic [FETCH_WIDTH-1:0] fq_mask;
  logic                   fq_ex;
  logic [4:0]             fq_exccode;
  logic                   fq_refill;
  logic                   fq_flush;

  modport master (
    output inst_vaddr, icache_req, fq_valid, fq_pc, fq_mask, fq_ex, fq_exccode,
           fq_refill, fq_flush,
    input  inst_tlb_ex, inst_tlb_exccode, inst_tlb_refill, icache_addr_ok, fq_ready
  );

  modport slave (
    input  inst_vaddr, icache_req, fq_valid, fq_pc, fq_mask, fq_ex, fq_exccode,
           fq_refill, fq_flush,
    output inst_tlb_ex, inst_tlb_exccode, inst_tlb_refill, icache_addr_ok, fq_ready
  );
endinterface

// File: rtl/multi_issue_pre_fetch_fifo.sv
// Request queue of fetch groups; head is read straight from storage flops.
// Clear wins over push/pop; full/empty come from the registered count only.
module fetch_req_fifo
  import multi_issue_pre_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  fetch_req_t push_dat,
  input  logic       pop,
  input  logic       clear,
  output logic       full,
  output logic       empty,
  output fetch_req_t head_dat
);
  localparam int PW = $clog2(DEPTH);

  fetch_req_t    mem_q [DEPTH];
  fetch_req_t    mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // payload needs no reset: nothing reads it while the count is zero
  always_ff @(posedge clk) mem_q <= mem_d;

endmodule

// File: rtl/multi_issue_pre_fetch.sv
// Pre-IF stage: redirect priority chain, group PC/mask generation, request queue.
// Optional PFS_PERF_CNT_EN adds stall / redirect performance counters.
module multi_issue_pre_fetch
  import multi_issue_pre_fetch_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter int          REQ_DEPTH   = 4,
  parameter logic [31:0] RESET_PC    = PFS_RESET_PC,
  parameter logic [31:0] EX_VEC      = PFS_EX_VEC,
  parameter logic [31:0] REFILL_VEC  = PFS_REFILL_VEC
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ex_flush,
  input  logic                         ex_refill,
  input  logic                         eret_flush,
  input  logic [31:0]                  c0_epc,
  input  logic                         replay_flush,
  input  logic [31:0]                  replay_pc,
  input  logic                         correct_valid,
  input  logic [31:0]                  correct_target,
  input  logic                         pred_valid,
  input  logic                         pred_taken,
  input  logic [$clog2(FETCH_WIDTH):0] pred_slot,
  input  logic [31:0]                  pred_target,
  multi_issue_pre_fetch_if.master      fif
`ifdef PFS_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_redirect_cnt
`endif
);
  localparam int GROUP_BYTES = FETCH_WIDTH * 4;

  logic [31:0]            pc_q, pc_d;
  logic                   halt_q, halt_d;
  logic                   flush_req, redirect, pred_hit, misaligned, exc;
  logic                   full, empty, req, req_push, ex_push, push, pop;
  logic [31:0]            base, next_pc, start_slot, end_slot;
  logic [FETCH_WIDTH-1:0] grp_mask;
  fetch_req_t             entry, head;
  logic                   unused_mask_hi;

  assign flush_req  = ex_flush | eret_flush | replay_flush | correct_valid;
  assign redirect   = reset | flush_req;
  assign pred_hit   = pred_valid & pred_taken;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign exc        = misaligned | fif.inst_tlb_ex;
  assign base       = pc_q & ~32'(GROUP_BYTES - 1);
  assign next_pc    = pred_hit ? pred_target : base + 32'(GROUP_BYTES);
  assign start_slot = (pc_q >> 2) & 32'(FETCH_WIDTH - 1);
  assign end_slot   = pred_hit ? 32'(pred_slot) : 32'(FETCH_WIDTH - 1);

  always_comb begin
    grp_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      grp_mask[i] = (32'(i) >= start_slot) && (32'(i) <= end_slot);
  end

  // an exception entry bypasses the I-cache and only needs queue space
  assign req      = ~halt_q & ~full & ~redirect & ~exc;
  assign req_push = req & fif.icache_addr_ok;
  assign ex_push  = ~halt_q & ~full & ~redirect & exc;
  assign push     = req_push | ex_push;
  assign pop      = ~empty & fif.fq_ready;

  always_comb begin
    entry            = '0;
    entry.pc         = pc_q;
    entry.mask       = MAX_FW'(grp_mask);
    entry.ex         = exc;
    entry.exccode    = misaligned ? EXCCODE_ADEL : (exc ? fif.inst_tlb_exccode : 5'd0);
    entry.tlb_refill = ~misaligned & fif.inst_tlb_ex & fif.inst_tlb_refill;
  end

  always_comb begin
    pc_d   = pc_q;
    halt_d = halt_q;
    if (reset) begin
      pc_d   = RESET_PC;
      halt_d = 1'b0;
    end else if (ex_flush) begin
      pc_d   = ex_refill ? REFILL_VEC : EX_VEC;
      halt_d = 1'b0;
    end else if (eret_flush) begin
      pc_d   = c0_epc;
      halt_d = 1'b0;
    end else if (replay_flush) begin
      pc_d   = replay_pc + 32'd4;
      halt_d = 1'b0;
    end else if (correct_valid) begin
      pc_d   = correct_target;
      halt_d = 1'b0;
    end else if (ex_push) begin
      halt_d = 1'b1;
    end else if (req_push) begin
      pc_d = next_pc;
    end
  end

  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    halt_q <= halt_d;
  end

  fetch_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (entry),
    .pop      (pop),
    .clear    (redirect),
    .full     (full),
    .empty    (empty),
    .head_dat (head)
  );

  assign unused_mask_hi   = ^head.mask;
  assign fif.inst_vaddr   = pc_q;
  assign fif.icache_req   = req;
  assign fif.fq_flush     = flush_req & ~reset;
  assign fif.fq_valid     = ~empty;
  assign fif.fq_pc        = empty ? 32'd0 : head.pc;
  assign fif.fq_mask      = empty ? '0 : head.mask[FETCH_WIDTH-1:0];
  assign fif.fq_ex        = ~empty & head.ex;
  assign fif.fq_exccode   = empty ? 5'd0 : head.exccode;
  assign fif.fq_refill    = ~empty & head.tlb_refill;

`ifdef PFS_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, redir_cnt_q, redir_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
      redir_cnt_d = '0;
    end else begin
      if (~halt_q & ~flush_req & (full | (req & ~fif.icache_addr_ok)))
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (flush_req) redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q <= stall_cnt_d;
    redir_cnt_q <= redir_cnt_d;
  end

  assign perf_stall_cnt    = stall_cnt_q;
  assign perf_redirect_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_multi_issue_pre_fetch.sv
// Bench for multi_issue_pre_fetch: directed vector table, corner sequences, random vs queue model.
module tb_multi_issue_pre_fetch;
  import multi_issue_pre_fetch_pkg::*;

  localparam int FW = 2;
  localparam int DEPTH = 4;
  localparam int SW = $clog2(FW) + 1;

  logic          clk = 1'b0;
  logic          reset, ex_flush, ex_refill, eret_flush, replay_flush, correct_valid;
  logic [31:0]   c0_epc, replay_pc, correct_target, pred_target;
  logic          pred_valid, pred_taken;
  logic [SW-1:0] pred_slot;
`ifdef PFS_PERF_CNT_EN
  logic [31:0]   perf_stall_cnt, perf_redirect_cnt;
`endif

  multi_issue_pre_fetch_if #(.FETCH_WIDTH(FW)) fif ();

  multi_issue_pre_fetch #(.FETCH_WIDTH(FW), .REQ_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_flush       (ex_flush),
    .ex_refill      (ex_refill),
    .eret_flush     (eret_flush),
    .c0_epc         (c0_epc),
    .replay_flush   (replay_flush),
    .replay_pc      (replay_pc),
    .correct_valid  (correct_valid),
    .correct_target (correct_target),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_slot      (pred_slot),
    .pred_target    (pred_target),
    .fif            (fif)
`ifdef PFS_PERF_CNT_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model: plain queue of groups ----------------
  fetch_req_t  mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

  function automatic logic [3:0] exp_mask(logic [31:0] pc, bit hit, int slot);
    int first = int'((pc >> 2) % FW);
    int last  = hit ? slot : FW - 1;
    logic [3:0] m = '0;
    for (int i = 0; i < FW; i++) if (i >= first && i <= last) m[i] = 1'b1;
    return m;
  endfunction

  function automatic bit any_flush();
    return ex_flush || eret_flush || replay_flush || correct_valid;
  endfunction

  function automatic bit m_exc();
    return (m_pc % 4 != 0) || fif.inst_tlb_ex;
  endfunction

  function automatic void mdl_check();
    bit redir = reset || any_flush();
    bit req   = !m_halt && mq.size() < DEPTH && !redir && !m_exc();
    chk("m_icache_req", fif.icache_req, req);
    chk("m_inst_vaddr", fif.inst_vaddr, m_pc);
    chk("m_fq_flush", fif.fq_flush, any_flush() && !reset);
    chk("m_fq_valid", fif.fq_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("m_fq_pc", fif.fq_pc, mq[0].pc);
      chk("m_fq_mask", fif.fq_mask, mq[0].mask[FW-1:0]);
      chk("m_fq_ex", fif.fq_ex, mq[0].ex);
      chk("m_fq_exccode", fif.fq_exccode, mq[0].exccode);
      chk("m_fq_refill", fif.fq_refill, mq[0].tlb_refill);
    end else begin
      chk("m_fq_pc_idle", fif.fq_pc, 32'd0);
    end
  endfunction

  function automatic void mdl_update();
    fetch_req_t e;
    bit hit = pred_valid && pred_taken;
    bit mis = (m_pc % 4 != 0);
    bit room = mq.size() < DEPTH;
    bit do_push;
    if (reset)              begin mq.delete(); m_halt = 0; m_pc = PFS_RESET_PC; end
    else if (ex_flush)      begin mq.delete(); m_halt = 0; m_pc = ex_refill ? PFS_REFILL_VEC : PFS_EX_VEC; end
    else if (eret_flush)    begin mq.delete(); m_halt = 0; m_pc = c0_epc; end
    else if (replay_flush)  begin mq.delete(); m_halt = 0; m_pc = replay_pc + 4; end
    else if (correct_valid) begin mq.delete(); m_halt = 0; m_pc = correct_target; end
    else begin
      do_push = !m_halt && room && (m_exc() || fif.icache_addr_ok);
      e.pc = m_pc;
      e.mask = exp_mask(m_pc, hit, int'(pred_slot));
      e.ex = m_exc();
      e.exccode = mis ? EXCCODE_ADEL : (fif.inst_tlb_ex ? fif.inst_tlb_exccode : 5'd0);
      e.tlb_refill = !mis && fif.inst_tlb_ex && fif.inst_tlb_refill;
      if (mq.size() > 0 && fif.fq_ready) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
        if (e.ex) m_halt = 1;
        else m_pc = hit ? pred_target : (m_pc & ~32'(FW * 4 - 1)) + FW * 4;
      end
    end
  endfunction

  task automatic cycle();
    #1 mdl_check();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic clr();
    reset = 0; ex_flush = 0; ex_refill = 0; eret_flush = 0; replay_flush = 0;
    correct_valid = 0; c0_epc = '0; replay_pc = '0; correct_target = '0;
    pred_valid = 0; pred_taken = 0; pred_slot = '0; pred_target = '0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t = $urandom;
    if ($urandom_range(0, 9) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          cv;  logic [31:0] ct;
    bit          pt;  int          ps;  logic [31:0] ptg;
    bit          e_req; logic [31:0] e_va; bit e_fv; logic [31:0] e_pc;
    logic [FW-1:0] e_mask; bit e_fl;
  } vec_t;

  vec_t vt[12];
  int   pushes;

  initial begin
    vt[0]  = '{0, 0, 0, 0, 0, 1, 32'hbfc00000, 0, 32'h0,        2'b00, 0};
    vt[1]  = '{0, 0, 0, 0, 0, 1, 32'hbfc00008, 1, 32'hbfc00000, 2'b11, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 1, 32'hbfc00010, 1, 32'hbfc00008, 2'b11, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 1, 32'hbfc00018, 1, 32'hbfc00010, 2'b11, 0};
    vt[4]  = '{1, 32'h80000004, 0, 0, 0, 0, 32'hbfc00020, 1, 32'hbfc00018, 2'b11, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 1, 32'h80000004, 0, 32'h0,        2'b00, 0};
    vt[6]  = '{0, 0, 0, 0, 0, 1, 32'h80000008, 1, 32'h80000004, 2'b10, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 1, 32'h80000010, 1, 32'h80000008, 2'b11, 0};
    vt[8]  = '{1, 32'h80000000, 0, 0, 0, 0, 32'h80000018, 1, 32'h80000010, 2'b11, 1};
    vt[9]  = '{0, 0, 1, 0, 32'h80001000, 1, 32'h80000000, 0, 32'h0, 2'b00, 0};
    vt[10] = '{0, 0, 0, 0, 0, 1, 32'h80001000, 1, 32'h80000000, 2'b01, 0};
    vt[11] = '{0, 0, 0, 0, 0, 1, 32'h80001008, 1, 32'h80001000, 2'b11, 0};

    clr();
    fif.inst_tlb_ex = 0; fif.inst_tlb_exccode = EXCCODE_TLBL; fif.inst_tlb_refill = 0;
    fif.icache_addr_ok = 1; fif.fq_ready = 1;
    reset = 1;
    m_pc = '0; m_halt = 0;
    @(posedge clk); mdl_update(); #1;
    #1;
    chk("rst_vaddr", fif.inst_vaddr, PFS_RESET_PC);
    chk("rst_req", fif.icache_req, 0);
    chk("rst_fq_valid", fif.fq_valid, 0);
    chk("rst_fq_flush", fif.fq_flush, 0);
    chk("rst_fq_mask", fif.fq_mask, 0);
    cycle();
    reset = 0;

    foreach (vt[k]) begin
      clr();
      correct_valid = vt[k].cv; correct_target = vt[k].ct;
      pred_valid = vt[k].pt; pred_taken = vt[k].pt;
      pred_slot = SW'(vt[k].ps); pred_target = vt[k].ptg;
      #1;
      chk($sformatf("vec%0d_req", k), fif.icache_req, vt[k].e_req);
      chk($sformatf("vec%0d_vaddr", k), fif.inst_vaddr, vt[k].e_va);
      chk($sformatf("vec%0d_fv", k), fif.fq_valid, vt[k].e_fv);
      chk($sformatf("vec%0d_pc", k), fif.fq_pc, vt[k].e_pc);
      chk($sformatf("vec%0d_mask", k), fif.fq_mask, vt[k].e_mask);
      chk($sformatf("vec%0d_flush", k), fif.fq_flush, vt[k].e_fl);
      cycle();
    end

    // queue fills to exactly DEPTH with IF stalled, then drains in order
    clr(); correct_valid = 1; correct_target = 32'h80000000; cycle();
    clr(); fif.fq_ready = 0; pushes = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (fif.icache_req) pushes++;
      if (i >= DEPTH) chk("full_no_req", fif.icache_req, 0);
      cycle();
    end
    chk("full_push_count", pushes, DEPTH);
    fif.fq_ready = 1; fif.icache_addr_ok = 0;
    for (int i = 0; i < DEPTH; i++) begin
      #1 chk("drain_order", fif.fq_pc, 32'h80000000 + 32'(8 * i));
      cycle();
    end
    fif.icache_addr_ok = 1;

    // misaligned fetch: exception entry, halt until an exception redirect
    for (int pass = 0; pass < 2; pass++) begin
      clr(); correct_valid = 1; correct_target = 32'h80000002; cycle();
      clr(); #1 chk("adel_no_req", fif.icache_req, 0); cycle();
      #1;
      chk("adel_fv", fif.fq_valid, 1);
      chk("adel_ex", fif.fq_ex, 1);
      chk("adel_code", fif.fq_exccode, EXCCODE_ADEL);
      chk("adel_pc", fif.fq_pc, 32'h80000002);
      cycle();
      for (int i = 0; i < 3; i++) begin
        #1 chk("halt_no_req", fif.icache_req, 0);
        cycle();
      end
      ex_flush = 1; ex_refill = (pass == 1); cycle();
      clr(); #1;
      chk("vec_vaddr", fif.inst_vaddr, pass == 1 ? PFS_REFILL_VEC : PFS_EX_VEC);
      chk("vec_req", fif.icache_req, 1);
      cycle();
    end

    // ERET while a push and pop are both possible: queue still empties
    cycle(); cycle();
    eret_flush = 1; c0_epc = 32'h80000100;
    #1 chk("eret_pre_fv", fif.fq_valid, 1);
    cycle();
    clr(); #1;
    chk("eret_empty", fif.fq_valid, 0);
    chk("eret_vaddr", fif.inst_vaddr, 32'h80000100);
    cycle();
    #1 chk("eret_head", fif.fq_pc, 32'h80000100);
    cycle();

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, 99);
      clr();
      if (r < 2) reset = 1;
      else if (r < 14) begin
        ex_flush = ($urandom_range(0, 3) == 0); ex_refill = $urandom_range(0, 1) == 1;
        eret_flush = ($urandom_range(0, 2) == 0); c0_epc = rand_tgt();
        replay_flush = ($urandom_range(0, 2) == 0); replay_pc = rand_tgt();
        correct_valid = 1; correct_target = rand_tgt();
      end
      pred_valid = $urandom_range(0, 1) == 1; pred_taken = $urandom_range(0, 1) == 1;
      pred_slot = SW'($urandom_range(0, FW - 1)); pred_target = rand_tgt();
      fif.inst_tlb_ex = ($urandom_range(0, 39) == 0);
      fif.inst_tlb_refill = $urandom_range(0, 1) == 1;
      fif.icache_addr_ok = $urandom_range(0, 3) != 0;
      fif.fq_ready = $urandom_range(0, 2) != 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
